multi_dataflow_tcdm_arb: RTL and testbench

Round-robin arbiter that shares one TCDM master port among the multi_dataflow streamer ports: inStream0, inStream1, inStream2 (loads) and outStream0 (store). It sits between the streamer's per-stream TCDM interfaces and the cluster interconnect port. It tracks each granted transaction with a fixed-latency tag pipeline so every response returns to the requester that issued it. A sticky protocol-error flag records any mismatch between expected and received responses.

---
 rtl/multi_dataflow_tcdm_arb.sv | 124 ++++++++++++
 tb/tb_multi_dataflow_tcdm_arb.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_dataflow_tcdm_arb.sv
// Round-robin arbiter sharing one TCDM master port among the multi_dataflow
// streamer ports (inStream0..2 loads, outStream0 store). A fixed-latency tag
// pipeline routes each response back to the requester that issued it. Any
// mismatch between expected and received responses sets a sticky error flag.
module multi_dataflow_tcdm_arb #(
  parameter int N_REQ    = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int RESP_LAT = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clear_i,
  input  logic [N_REQ-1:0]          in_req_i,
  output logic [N_REQ-1:0]          in_gnt_o,
  input  logic [N_REQ*ADDR_W-1:0]   in_add_i,
  input  logic [N_REQ-1:0]          in_wen_i,
  input  logic [N_REQ*DATA_W/8-1:0] in_be_i,
  input  logic [N_REQ*DATA_W-1:0]   in_data_i,
  output logic [N_REQ-1:0]          in_r_valid_o,
  output logic [DATA_W-1:0]         in_r_data_o,
  output logic                      out_req_o,
  input  logic                      out_gnt_i,
  output logic [ADDR_W-1:0]         out_add_o,
  output logic                      out_wen_o,
  output logic [DATA_W/8-1:0]       out_be_o,
  output logic [DATA_W-1:0]         out_data_o,
  input  logic                      out_r_valid_i,
  input  logic [DATA_W-1:0]         out_r_data_i,
  output logic                      busy_o,
  output logic                      err_o
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int LAST  = RESP_LAT - 1;

  logic                flush;
  logic                hs;
  logic                found;
  logic [IDX_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]    rr_next;
  logic [IDX_W-1:0]    win;
  logic [IDX_W-1:0]    cand;
  logic                err;

  // tag_drop marks stages whose tag was flushed by a clear: the memory will
  // still answer those, and such a response must be absorbed silently.
  logic [RESP_LAT-1:0] tag_v;
  logic [RESP_LAT-1:0] tag_drop;
  logic [IDX_W-1:0]    tag_idx [RESP_LAT];

  assign flush = rst_i | clear_i;

  // Winner: first requester found scanning from rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    win   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = IDX_W'((int'(rr_ptr) + i) % N_REQ);
      if (!found && in_req_i[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  // Payload mux from the winner; index 0 when nobody requests.
  always_comb begin
    out_add_o  = in_add_i[ADDR_W-1:0];
    out_wen_o  = in_wen_i[0];
    out_be_o   = in_be_i[BE_W-1:0];
    out_data_o = in_data_i[DATA_W-1:0];
    for (int i = 1; i < N_REQ; i++) begin
      if (win == IDX_W'(i)) begin
        out_add_o  = in_add_i[i*ADDR_W +: ADDR_W];
        out_wen_o  = in_wen_i[i];
        out_be_o   = in_be_i[i*BE_W +: BE_W];
        out_data_o = in_data_i[i*DATA_W +: DATA_W];
      end
    end
  end

  assign out_req_o = (|in_req_i) & ~flush;
  assign hs        = out_req_o & out_gnt_i;
  assign in_gnt_o  = hs ? (N_REQ'(1) << win) : '0;
  assign rr_next   = (win == IDX_W'(N_REQ - 1)) ? '0 : win + 1'b1;

  assign in_r_valid_o = (tag_v[LAST] & out_r_valid_i & ~flush)
                        ? (N_REQ'(1) << tag_idx[LAST]) : '0;
  assign in_r_data_o  = out_r_data_i;
  assign busy_o       = |tag_v;
  assign err_o        = err;

  // Pointer advance, tag pipeline shift and sticky error tracking.
  always_ff @(posedge clk_i) begin
    if (flush) begin
      rr_ptr      <= '0;
      err         <= 1'b0;
      tag_v       <= '0;
      tag_drop[0] <= 1'b0;
      for (int k = 1; k < RESP_LAT; k++) begin
        tag_drop[k] <= tag_drop[k-1] | tag_v[k-1];
      end
    end else begin
      if (hs) begin
        rr_ptr <= rr_next;
      end
      tag_v[0]    <= hs;
      tag_idx[0]  <= win;
      tag_drop[0] <= 1'b0;
      for (int k = 1; k < RESP_LAT; k++) begin
        tag_v[k]    <= tag_v[k-1];
        tag_idx[k]  <= tag_idx[k-1];
        tag_drop[k] <= tag_drop[k-1];
      end
      if ((tag_v[LAST] != out_r_valid_i) && !(tag_drop[LAST] && out_r_valid_i)) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multi_dataflow_tcdm_arb.sv
// Scoreboard bench for multi_dataflow_tcdm_arb with a fixed-latency TCDM model.
module tb_multi_dataflow_tcdm_arb;

  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BW  = DW / 8;
  localparam int LAT = 2;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              clear_i;
  logic [N-1:0]      in_req_i;
  logic [N-1:0]      in_gnt_o;
  logic [N*AW-1:0]   in_add_i;
  logic [N-1:0]      in_wen_i;
  logic [N*BW-1:0]   in_be_i;
  logic [N*DW-1:0]   in_data_i;
  logic [N-1:0]      in_r_valid_o;
  logic [DW-1:0]     in_r_data_o;
  logic              out_req_o;
  logic              out_gnt_i;
  logic [AW-1:0]     out_add_o;
  logic              out_wen_o;
  logic [BW-1:0]     out_be_o;
  logic [DW-1:0]     out_data_o;
  logic              out_r_valid_i;
  logic [DW-1:0]     out_r_data_i;
  logic              busy_o;
  logic              err_o;

  always #5 clk_i = ~clk_i;

  multi_dataflow_tcdm_arb #(
    .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RESP_LAT(LAT)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
    .in_req_i(in_req_i), .in_gnt_o(in_gnt_o), .in_add_i(in_add_i),
    .in_wen_i(in_wen_i), .in_be_i(in_be_i), .in_data_i(in_data_i),
    .in_r_valid_o(in_r_valid_o), .in_r_data_o(in_r_data_o),
    .out_req_o(out_req_o), .out_gnt_i(out_gnt_i), .out_add_o(out_add_o),
    .out_wen_o(out_wen_o), .out_be_o(out_be_o), .out_data_o(out_data_o),
    .out_r_valid_i(out_r_valid_i), .out_r_data_i(out_r_data_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  typedef struct {
    int            cyc;
    int            idx;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            m_rr = 0;
  logic          m_err = 1'b0;
  logic          chk_en = 1'b0;
  logic          inject = 1'b0;
  logic          mv [LAT];
  logic [DW-1:0] md [LAT];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic int winner(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return 0;
  endfunction

  // Memory contents seen through the TCDM model.
  function automatic logic [DW-1:0] memfn(input logic [AW-1:0] a);
    return (a == 32'h100) ? 32'hDEAD_BEEF : (a ^ 32'hC0DE_5A5A);
  endfunction

  task automatic set_port(input int i, input logic [AW-1:0] a, input logic w,
                          input logic [BW-1:0] b, input logic [DW-1:0] d);
    in_add_i[i*AW +: AW]  = a;
    in_wen_i[i]           = w;
    in_be_i[i*BW +: BW]   = b;
    in_data_i[i*DW +: DW] = d;
  endtask

  // One clock cycle: drive the TCDM response, check outputs at the falling
  // edge against the model, then advance model and memory pipeline.
  task automatic cycle();
    int            w;
    logic          hs;
    logic          fl;
    logic          busy_exp;
    logic [N-1:0]  egnt;
    logic [N-1:0]  erv;
    logic [DW-1:0] ed;
    logic [AW-1:0] wa;
    exp_t          e;
    out_r_valid_i = mv[LAT-1] | inject;
    out_r_data_i  = inject ? 32'h0BAD_F00D : md[LAT-1];
    @(negedge clk_i);
    fl       = rst_i | clear_i;
    w        = winner(in_req_i, m_rr);
    wa       = in_add_i[w*AW +: AW];
    hs       = (|in_req_i) & out_gnt_i & ~fl;
    egnt     = hs ? N'(1 << w) : '0;
    busy_exp = (sb.size() > 0);
    erv      = '0;
    ed       = '0;
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      if (!fl) begin
        erv = N'(1 << e.idx);
        ed  = e.data;
      end
    end
    if (chk_en) begin
      chk("out_req", 64'(out_req_o), 64'((|in_req_i) & ~fl));
      chk("gnt", 64'(in_gnt_o), 64'(egnt));
      chk("busy", 64'(busy_o), 64'(busy_exp));
      chk("err", 64'(err_o), 64'(m_err));
      chk("r_valid", 64'(in_r_valid_o), 64'(erv));
      if (erv != '0) chk("r_data", 64'(in_r_data_o), 64'(ed));
      if (|in_req_i) begin
        chk("add", 64'(out_add_o), 64'(wa));
        chk("wen", 64'(out_wen_o), 64'(in_wen_i[w]));
        chk("be", 64'(out_be_o), 64'(in_be_i[w*BW +: BW]));
        chk("wdata", 64'(out_data_o), 64'(in_data_i[w*DW +: DW]));
      end
    end
    if (fl) begin
      sb.delete();
      m_rr  = 0;
      m_err = 1'b0;
    end else begin
      if (inject) m_err = 1'b1;
      if (hs) begin
        sb.push_back('{cyc + LAT, w, memfn(wa)});
        m_rr = (w + 1) % N;
      end
    end
    @(posedge clk_i);
    for (int k = LAT - 1; k > 0; k--) begin
      mv[k] = mv[k-1];
      md[k] = md[k-1];
    end
    mv[0]  = hs;
    md[0]  = memfn(wa);
    cyc++;
    inject = 1'b0;
    #1;
  endtask

  initial begin
    rst_i = 1'b1; clear_i = 1'b0; in_req_i = '0; in_add_i = '0;
    in_wen_i = '1; in_be_i = '1; in_data_i = '0; out_gnt_i = 1'b0;
    out_r_valid_i = 1'b0; out_r_data_i = '0;
    for (int k = 0; k < LAT; k++) begin mv[k] = 1'b0; md[k] = '0; end
    repeat (3) cycle();

    // Reset state with requests and grant present: nothing may leak out.
    chk_en = 1'b1;
    in_req_i = '1; out_gnt_i = 1'b1;
    cycle();
    rst_i = 1'b0;

    // All ports requesting: rotation 0,1,2,3,0,1.
    for (int i = 0; i < N; i++) set_port(i, AW'(32'h1000 + i * 16), 1'b1, 4'hF, DW'(32'hA000 + i));
    in_req_i = 4'b1111;
    repeat (6) cycle();

    // Port 3 wraps pointer to 0, then port 2 alone every cycle.
    in_req_i = 4'b1000; cycle();
    in_req_i = 4'b0100; repeat (4) cycle();

    // Single read from port 1 at 0x100.
    set_port(1, 32'h100, 1'b1, 4'hF, 32'h0);
    in_req_i = 4'b0010; cycle();
    in_req_i = 4'b0000; repeat (3) cycle();

    // Stalled grant with ports 0 and 3, then release.
    in_req_i = 4'b1000; cycle();
    set_port(3, 32'h2000, 1'b0, 4'h3, 32'h1234_5678);
    in_req_i = 4'b1001; out_gnt_i = 1'b0;
    repeat (5) cycle();
    out_gnt_i = 1'b1; cycle();
    in_req_i = 4'b1000; cycle();
    in_req_i = 4'b0000; repeat (3) cycle();

    // Clear while a response is in flight: it is dropped without error.
    in_req_i = 4'b0100; cycle();
    in_req_i = 4'b0000; clear_i = 1'b1; cycle();
    clear_i = 1'b0; repeat (3) cycle();

    // Random traffic with occasional clears.
    repeat (300) begin
      in_req_i  = N'($urandom);
      out_gnt_i = ($urandom_range(0, 3) != 0);
      clear_i   = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < N; i++)
        set_port(i, AW'($urandom), 1'($urandom), BW'($urandom), DW'($urandom));
      cycle();
    end
    clear_i = 1'b0; in_req_i = '0;
    repeat (LAT + 1) cycle();

    // Spurious response sets a sticky error, cleared only by clear.
    inject = 1'b1; cycle();
    repeat (3) cycle();
    clear_i = 1'b1; cycle();
    clear_i = 1'b0; repeat (2) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
